// File: rtl/ipml_prefetch_pkg.sv
// Shared constants and helpers for the ipml read-side prefetch engine.
// The elaboration-check macro expands to a generate block inside the including module.
package ipml_prefetch_pkg;

  localparam int unsigned LAT_MIN  = 1;
  localparam int unsigned LAT_MAX  = 3;
  localparam int unsigned SKID_MIN = 2;
  localparam int unsigned SKID_MAX = 16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = 1;
    while (v < value) begin
      v   = v << 1;
      res = res + 1;
    end
    return res;
  endfunction

endpackage

`define IPML_PREFETCH_CHECK(skid, lat) \
  if ((skid) < (lat)) begin : g_skid_lat_chk \
    $error("ipml_prefetch: c_SKID_DEPTH must be >= c_RD_LATENCY"); \
  end

// File: rtl/ipml_prefetch_skid_buf.sv
// Circular register skid buffer with push/pop/flush, occupancy count and sticky overflow.
module ipml_prefetch_skid_buf
  import ipml_prefetch_pkg::*;
#(
  parameter int unsigned c_DATA_WIDTH = 32,
  parameter int unsigned c_DEPTH      = 2,
  parameter int unsigned c_LVL_W      = clog2(c_DEPTH + 1)
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic [c_DATA_WIDTH-1:0] push_data,
  input  logic                    pop,
  output logic [c_DATA_WIDTH-1:0] head_data,
  output logic [c_LVL_W-1:0]      count,
  output logic                    empty,
  output logic                    ovf_err
);

  localparam int unsigned PTR_W = (clog2(c_DEPTH) > 0) ? clog2(c_DEPTH) : 1;
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(c_DEPTH - 1);
  localparam logic [c_LVL_W-1:0] CNT_FULL = c_LVL_W'(c_DEPTH);

  logic [c_DATA_WIDTH-1:0] mem_q [c_DEPTH];
  logic [c_DATA_WIDTH-1:0] mem_d [c_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_LVL_W-1:0]      count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    full, pop_ok, push_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  // When full, a push is only accepted alongside a pop (slot being vacated this cycle).
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_ok && !pop_ok)      count_d = count_q + c_LVL_W'(1);
      else if (pop_ok && !push_ok) count_d = count_q - c_LVL_W'(1);
      if (push && !push_ok) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      for (int unsigned i = 0; i < c_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign ovf_err   = ovf_q;

endmodule

// File: rtl/ipml_prefetch_rd_stage.sv
// Read-side prefetch: SDPRAM read port + empty flag -> FWFT valid/ready stream.
// Credit-based issue guarantees returning words always find room in the skid buffer.
module ipml_prefetch_rd_stage
  import ipml_prefetch_pkg::*;
#(
  parameter int unsigned c_DATA_WIDTH = 32,
  parameter int unsigned c_RD_LATENCY = 1,
  parameter int unsigned c_SKID_DEPTH = 2,
  parameter int unsigned c_LVL_W      = clog2(c_SKID_DEPTH + 1)
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  input  logic                    flush,
  input  logic                    ram_empty,
  output logic                    ram_rd_en,
  input  logic [c_DATA_WIDTH-1:0] ram_rd_data,
  output logic [c_DATA_WIDTH-1:0] out_data,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [c_LVL_W-1:0]      out_level,
  output logic                    ovf_err
);

  `IPML_PREFETCH_CHECK(c_SKID_DEPTH, c_RD_LATENCY)

  if (c_RD_LATENCY < LAT_MIN || c_RD_LATENCY > LAT_MAX ||
      c_SKID_DEPTH < SKID_MIN || c_SKID_DEPTH > SKID_MAX) begin : g_range_chk
    $error("ipml_prefetch: parameter out of legal range");
  end

  localparam int unsigned CRD_W = c_LVL_W + 2;

  logic [c_RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [CRD_W-1:0]        inflight, credit_used;
  logic                    pop, buf_empty;

  assign pop = out_vld & out_rdy;

  // Words already popped this cycle free their slot, hence the out_rdy -> ram_rd_en path.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < c_RD_LATENCY; i++) inflight = inflight + CRD_W'(vld_pipe_q[i]);
    credit_used = CRD_W'(out_level) + inflight - CRD_W'(pop);
    ram_rd_en   = ~rd_rst & ~ram_empty & ~flush & (credit_used < CRD_W'(c_SKID_DEPTH));
    vld_pipe_d  = flush ? '0 : c_RD_LATENCY'({vld_pipe_q, ram_rd_en});
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) vld_pipe_q <= '0;
    else        vld_pipe_q <= vld_pipe_d;
  end

  ipml_prefetch_skid_buf #(
    .c_DATA_WIDTH (c_DATA_WIDTH),
    .c_DEPTH      (c_SKID_DEPTH),
    .c_LVL_W      (c_LVL_W)
  ) u_skid (
    .rd_clk    (rd_clk),
    .rd_rst    (rd_rst),
    .flush     (flush),
    .push      (vld_pipe_q[c_RD_LATENCY-1]),
    .push_data (ram_rd_data),
    .pop       (pop),
    .head_data (out_data),
    .count     (out_level),
    .empty     (buf_empty),
    .ovf_err   (ovf_err)
  );

  assign out_vld = ~buf_empty;

endmodule

// File: tb/tb_ipml_prefetch_rd_stage.sv
// Directed bench for ipml_prefetch_rd_stage: three configurations, each fed by a model RAM.
module tb_ipml_prefetch_rd_stage;
  import ipml_prefetch_pkg::*;

  localparam int unsigned NI = 3;
  localparam int unsigned LAT_P  [NI] = '{2, 1, 3};
  localparam int unsigned SKID_P [NI] = '{3, 2, 5};

  logic        rd_clk = 1'b0;
  logic        rd_rst;
  logic        flush_i     [NI];
  logic        force_empty [NI];
  logic        out_rdy_i   [NI];
  int unsigned lim         [NI];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned exp_c = 0;

  always #5 rd_clk = ~rd_clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned L  = LAT_P[g];
    localparam int unsigned S  = SKID_P[g];
    localparam int unsigned LW = clog2(S + 1);
    logic          ram_empty, ram_rd_en, out_vld, ovf_err;
    logic [31:0]   ram_rd_data, out_data;
    logic [LW-1:0] out_level;
    logic [31:0]   ptr = '0;
    logic [31:0]   pipe [L];

    // Model controller/RAM: word n holds value n; garbage when no read was issued.
    assign ram_empty   = force_empty[g] | (ptr >= lim[g]);
    assign ram_rd_data = pipe[L-1];
    always @(posedge rd_clk) begin
      if (ram_rd_en) ptr <= ptr + 1;
      pipe[0] <= ram_rd_en ? ptr : 32'hDEAD_BEEF;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end

    ipml_prefetch_rd_stage #(
      .c_DATA_WIDTH (32),
      .c_RD_LATENCY (L),
      .c_SKID_DEPTH (S)
    ) u_dut (
      .rd_clk      (rd_clk),
      .rd_rst      (rd_rst),
      .flush       (flush_i[g]),
      .ram_empty   (ram_empty),
      .ram_rd_en   (ram_rd_en),
      .ram_rd_data (ram_rd_data),
      .out_data    (out_data),
      .out_vld     (out_vld),
      .out_rdy     (out_rdy_i[g]),
      .out_level   (out_level),
      .ovf_err     (ovf_err)
    );
  end

  task automatic test_reset();
    rd_rst = 1'b1;
    for (int g = 0; g < NI; g++) begin
      flush_i[g] = 1'b0; force_empty[g] = 1'b0; out_rdy_i[g] = 1'b0; lim[g] = 1000;
    end
    repeat (2) @(negedge rd_clk);
    #1;
    n_cmp++;
    if ({g_dut[0].out_vld, g_dut[1].out_vld, g_dut[2].out_vld} !== 3'b000) begin
      n_err++; $display("FAIL rst_vld: got %b%b%b want 000", g_dut[0].out_vld, g_dut[1].out_vld, g_dut[2].out_vld);
    end
    n_cmp++;
    if ({g_dut[0].ram_rd_en, g_dut[1].ram_rd_en, g_dut[2].ram_rd_en} !== 3'b000) begin
      n_err++; $display("FAIL rst_rd_en: got %b%b%b want 000", g_dut[0].ram_rd_en, g_dut[1].ram_rd_en, g_dut[2].ram_rd_en);
    end
    n_cmp++;
    if ({g_dut[0].ovf_err, g_dut[1].ovf_err, g_dut[2].ovf_err} !== 3'b000) begin
      n_err++; $display("FAIL rst_ovf: got %b%b%b want 000", g_dut[0].ovf_err, g_dut[1].ovf_err, g_dut[2].ovf_err);
    end
    n_cmp++;
    if (g_dut[0].out_level !== 0 || g_dut[1].out_level !== 0 || g_dut[2].out_level !== 0) begin
      n_err++; $display("FAIL rst_level: got %0d/%0d/%0d want 0", g_dut[0].out_level, g_dut[1].out_level, g_dut[2].out_level);
    end
    n_cmp++;
    if (g_dut[0].out_data !== 0 || g_dut[1].out_data !== 0 || g_dut[2].out_data !== 0) begin
      n_err++; $display("FAIL rst_data: got %h/%h/%h want 0", g_dut[0].out_data, g_dut[1].out_data, g_dut[2].out_data);
    end
    for (int g = 0; g < NI; g++) force_empty[g] = 1'b1;
    @(negedge rd_clk);
    rd_rst = 1'b0;
  endtask

  // L=2, S=3: 8 words, one per cycle, first word after 3 cycles.
  task automatic test_latency();
    logic exp_en, exp_v;
    lim[0] = 8; out_rdy_i[0] = 1'b1;
    for (int c = 0; c < 13; c++) begin
      @(negedge rd_clk);
      force_empty[0] = 1'b0;
      #1;
      exp_en = (c < 8);
      exp_v  = (c >= 3 && c <= 10);
      n_cmp++;
      if (g_dut[0].ram_rd_en !== exp_en) begin
        n_err++; $display("FAIL lat_rd_en cyc %0d: got %b want %b", c, g_dut[0].ram_rd_en, exp_en);
      end
      n_cmp++;
      if (g_dut[0].out_vld !== exp_v) begin
        n_err++; $display("FAIL lat_vld cyc %0d: got %b want %b", c, g_dut[0].out_vld, exp_v);
      end
      if (exp_v) begin
        n_cmp++;
        if (g_dut[0].out_data !== 32'(c - 3)) begin
          n_err++; $display("FAIL lat_data cyc %0d: got %0d want %0d", c, g_dut[0].out_data, c - 3);
        end
      end
    end
    force_empty[0] = 1'b1;
  endtask

  // L=1, S=2: stalled consumer -> exactly 2 reads, then 0,1,2,3 back-to-back.
  task automatic test_backpressure();
    int unsigned n_rd = 0;
    out_rdy_i[1] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge rd_clk);
      force_empty[1] = 1'b0;
      #1;
      if (g_dut[1].ram_rd_en === 1'b1) n_rd++;
      if (c >= 3) begin
        n_cmp++;
        if (g_dut[1].out_vld !== 1'b1 || g_dut[1].out_data !== 0) begin
          n_err++; $display("FAIL bp_hold cyc %0d: got vld=%b data=%0d want vld=1 data=0", c, g_dut[1].out_vld, g_dut[1].out_data);
        end
      end
    end
    n_cmp++;
    if (n_rd != 2) begin n_err++; $display("FAIL bp_reads: got %0d want 2", n_rd); end
    n_cmp++;
    if (g_dut[1].out_level !== 2) begin n_err++; $display("FAIL bp_level: got %0d want 2", g_dut[1].out_level); end
    n_cmp++;
    if (g_dut[1].ovf_err !== 1'b0) begin n_err++; $display("FAIL bp_ovf: got %b want 0", g_dut[1].ovf_err); end
    for (int k = 0; k < 4; k++) begin
      @(negedge rd_clk);
      out_rdy_i[1] = 1'b1;
      #1;
      n_cmp++;
      if (g_dut[1].out_vld !== 1'b1 || g_dut[1].out_data !== 32'(k)) begin
        n_err++; $display("FAIL bp_stream k %0d: got vld=%b data=%0d want vld=1 data=%0d", k, g_dut[1].out_vld, g_dut[1].out_data, k);
      end
    end
    force_empty[1] = 1'b1;
    repeat (6) @(negedge rd_clk);
    #1;
    n_cmp++;
    if (g_dut[1].out_level !== 0) begin n_err++; $display("FAIL bp_drain: got level %0d want 0", g_dut[1].out_level); end
  endtask

  // L=3, S=5: 1000 words under random out_rdy.
  task automatic test_random();
    int unsigned pops = 0;
    lim[2] = 1000; exp_c = 0;
    for (int c = 0; c < 20000 && pops < 1000; c++) begin
      @(negedge rd_clk);
      force_empty[2] = 1'b0;
      out_rdy_i[2]   = 1'($urandom_range(0, 1));
      #1;
      n_cmp++;
      if (g_dut[2].out_level > 5 || g_dut[2].ovf_err !== 1'b0) begin
        n_err++; $display("FAIL rnd_level cyc %0d: got level=%0d ovf=%b want <=5 ovf=0", c, g_dut[2].out_level, g_dut[2].ovf_err);
      end
      if (g_dut[2].out_vld === 1'b1 && out_rdy_i[2]) begin
        n_cmp++;
        if (g_dut[2].out_data !== exp_c) begin
          n_err++; $display("FAIL rnd_data pop %0d: got %0d want %0d", pops, g_dut[2].out_data, exp_c);
        end
        exp_c++; pops++;
      end
    end
    n_cmp++;
    if (pops != 1000) begin n_err++; $display("FAIL rnd_count: got %0d pops want 1000", pops); end
  endtask

  // L=3, S=5: ram_empty toggling every 3 cycles.
  task automatic test_empty_toggle();
    lim[2] = 2000; out_rdy_i[2] = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(negedge rd_clk);
      force_empty[2] = (c >= 60) ? 1'b1 : 1'(((c / 3) % 2) == 1);
      #1;
      n_cmp++;
      if (g_dut[2].ram_rd_en === 1'b1 && g_dut[2].ram_empty === 1'b1) begin
        n_err++; $display("FAIL tog_rd_en cyc %0d: got rd_en=1 with empty=1 want rd_en=0", c);
      end
      if (g_dut[2].out_vld === 1'b1) begin
        n_cmp++;
        if (g_dut[2].out_data !== exp_c) begin
          n_err++; $display("FAIL tog_data cyc %0d: got %0d want %0d", c, g_dut[2].out_data, exp_c);
        end
        exp_c++;
      end
    end
    n_cmp++;
    if (exp_c != g_dut[2].ptr || g_dut[2].out_vld !== 1'b0) begin
      n_err++; $display("FAIL tog_total: got %0d delivered vld=%b want %0d vld=0", exp_c, g_dut[2].out_vld, g_dut[2].ptr);
    end
  endtask

  // L=2, S=3: flush at cycle 6 drops words 12,13; next output is word 14.
  task automatic test_flush();
    logic        exp_en, exp_v;
    logic [31:0] exp_d;
    lim[0] = 1000; out_rdy_i[0] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge rd_clk);
      force_empty[0] = 1'b0;
      flush_i[0]     = (c == 6);
      #1;
      exp_en = (c != 6);
      exp_v  = (c >= 3 && c <= 6) || (c >= 10);
      exp_d  = (c <= 6) ? 32'(c + 5) : 32'(c + 4);
      n_cmp++;
      if (g_dut[0].ram_rd_en !== exp_en) begin
        n_err++; $display("FAIL fl_rd_en cyc %0d: got %b want %b", c, g_dut[0].ram_rd_en, exp_en);
      end
      n_cmp++;
      if (g_dut[0].out_vld !== exp_v) begin
        n_err++; $display("FAIL fl_vld cyc %0d: got %b want %b", c, g_dut[0].out_vld, exp_v);
      end
      if (exp_v) begin
        n_cmp++;
        if (g_dut[0].out_data !== exp_d) begin
          n_err++; $display("FAIL fl_data cyc %0d: got %0d want %0d", c, g_dut[0].out_data, exp_d);
        end
      end
    end
    flush_i[0] = 1'b0; force_empty[0] = 1'b1;
    repeat (6) @(negedge rd_clk);
  endtask

  // L=2, S=3: reset with 2 words buffered and 1 in flight.
  task automatic test_midreset();
    out_rdy_i[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge rd_clk);
      force_empty[0] = 1'b0;
    end
    #1;
    n_cmp++;
    if (g_dut[0].out_level !== 2) begin n_err++; $display("FAIL mr_pre_level: got %0d want 2", g_dut[0].out_level); end
    rd_rst = 1'b1;
    #1;
    n_cmp++;
    if (g_dut[0].out_vld !== 1'b0 || g_dut[0].out_level !== 0 || g_dut[0].ovf_err !== 1'b0 || g_dut[0].ram_rd_en !== 1'b0) begin
      n_err++; $display("FAIL mr_clear: got vld=%b level=%0d ovf=%b rd_en=%b want 0/0/0/0",
                        g_dut[0].out_vld, g_dut[0].out_level, g_dut[0].ovf_err, g_dut[0].ram_rd_en);
    end
    @(negedge rd_clk);
    rd_rst = 1'b0; force_empty[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge rd_clk);
      #1;
      n_cmp++;
      if (g_dut[0].out_level !== 0 || g_dut[0].out_vld !== 1'b0) begin
        n_err++; $display("FAIL mr_late cyc %0d: got level=%0d vld=%b want 0/0", c, g_dut[0].out_level, g_dut[0].out_vld);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_random();
    test_empty_toggle();
    test_flush();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ipml_prefetch_rd_stage.md
Name: ipml_prefetch_rd_stage

Overview:
- Parametrised read-side prefetch engine for the ipml FIFO family.
- Turns a synchronous SDPRAM read port of configurable latency (1..3 cycles) plus a FIFO-controller empty flag into a first-word-fall-through valid/ready stream.
- Skid depth is configurable. Adds occupancy level, synchronous flush and an overflow error flag.
- Sits between the FIFO controller/SDPRAM read port and the consumer, entirely in the rd_clk domain.

Parameters:
- c_DATA_WIDTH, 32, read data width; legal 1..1152.
- c_RD_LATENCY, 1, cycles from ram_rd_en to valid ram_rd_data; legal 1..3 (1 = no output reg, 2 = output reg, 3 = extra pipeline).
- c_SKID_DEPTH, 2, skid buffer entries; legal 2..16. Must be >= c_RD_LATENCY+1 for 1 word/cycle throughput; elaboration error if < c_RD_LATENCY.
- c_LVL_W, derived = clog2(c_SKID_DEPTH+1), width of the level/count output.

Ports:
- rd_clk, input, 1, read clock.
- rd_rst, input, 1, reset, asynchronous, active-high.
- flush, input, 1, synchronous discard of skid contents and in-flight reads.
- ram_empty, input, 1, FIFO controller empty flag.
- ram_rd_en, output, 1, read request to controller and RAM (one word per high cycle).
- ram_rd_data, input, c_DATA_WIDTH, RAM read data, valid c_RD_LATENCY cycles after ram_rd_en.
- out_data, output, c_DATA_WIDTH, head-of-stream data.
- out_vld, output, 1, out_data valid.
- out_rdy, input, 1, consumer accept.
- out_level, output, c_LVL_W, words held in skid buffer.
- ovf_err, output, 1, sticky: a returning word found the skid buffer full.

Behaviour:
- Reset (async assert, rd_clk-synchronous release) values:
  - out_vld=0, out_level=0, ovf_err=0, out_data=0.
  - Pointers and in-flight pipe cleared.
  - ram_rd_en=0 while rd_rst is high.
- pop = out_vld & out_rdy. One word leaves per pop.
- inflight = count of set bits in the c_RD_LATENCY-deep valid shift pipe.
- ram_rd_en (combinational) = ~ram_empty & ~flush & (out_level + inflight - pop < c_SKID_DEPTH).
  - This is a credit scheme: reads are never issued that could overflow the skid buffer.
  - The path from out_rdy to ram_rd_en is combinational by design.
- Issue in cycle t:
  - vld_pipe[0] is set at the end of cycle t.
  - ram_rd_data is sampled at the end of cycle t+c_RD_LATENCY and written at wr_ptr.
  - out_vld is high from cycle t+c_RD_LATENCY+1 when the buffer was empty. First-word latency is c_RD_LATENCY+1 cycles from ram_rd_en.
- Skid buffer:
  - Circular register array with wr_ptr/rd_ptr wrapping at c_SKID_DEPTH (non-power-of-2 supported) and a count register.
  - out_data = mem[rd_ptr], registered storage with no combinational path from ram_rd_data.
  - out_vld = (count != 0). out_level = count.
- Simultaneous push and pop: count is unchanged and both pointers advance. Legal when full (count == c_SKID_DEPTH).
- Push when full without a pop: cannot happen under the credit scheme. If it does, the word is dropped, count saturates and ovf_err is set until reset.
- Backpressure: out_data and out_vld hold stable while out_vld & ~out_rdy.
- Steady state, with c_SKID_DEPTH >= c_RD_LATENCY+1 and out_rdy held 1: one word per cycle with no bubbles.
- flush (one cycle, highest priority):
  - count, wr_ptr, rd_ptr and vld_pipe all clear at the end of the cycle.
  - ram_rd_en=0 that cycle. out_vld=0 next cycle.
  - Words already read from the RAM are discarded; the controller's read pointer is not rewound.
  - A pop in the flush cycle is still a valid transfer for the consumer.
- ram_empty rising mid-burst: issue stops the same cycle; in-flight words still land.
- rd_rst mid-operation: everything clears immediately; in-flight returns are ignored.

Decomposition:
- Package ipml_prefetch_pkg:
  - clog2 function.
  - Legal-range constants: LAT_MIN=1, LAT_MAX=3, SKID_MIN=2, SKID_MAX=16.
  - Elaboration check macro for c_SKID_DEPTH vs c_RD_LATENCY.
- One sub-module, ipml_prefetch_skid_buf: circular register buffer with push/pop/flush, count, full/empty and ovf_err.
- The top level holds the credit logic and the valid pipe.

Test Plan:
- Latency, c_RD_LATENCY=2, c_SKID_DEPTH=3, out_rdy=1: 8 words (values 0..7) preloaded in the model RAM, ram_empty falls at cycle 0 -> ram_rd_en high cycles 0..7; out_vld high cycles 3..10; out_data 0..7 in order with no gaps.
- Backpressure, c_RD_LATENCY=1, c_SKID_DEPTH=2: out_rdy=0 for 10 cycles -> ram_rd_en issues exactly 2 reads; out_level=2; out_data holds word 0; ovf_err=0. out_rdy=1 then -> words 1,2,3 follow back-to-back.
- Random out_rdy (50%), c_RD_LATENCY=3, c_SKID_DEPTH=5, 1000 words -> exact in-order match against a scoreboard; ovf_err never set; out_level <= 5 always.
- Flush at cycle 6 of a streaming burst with 2 reads in flight -> out_vld=0 at cycle 7; the 2 in-flight words never appear; the next output is the next RAM word after ram_rd_en resumes at cycle 7.
- ram_empty toggling every 3 cycles with out_rdy=1 -> reads issue only while ram_empty=0; no duplicated or lost words.
- rd_rst asserted for 1 cycle while out_level=2 with 1 word in flight -> out_vld, out_level and ovf_err go to 0 immediately; the late ram_rd_data return is ignored (out_level stays 0).
